// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage: PC register and IF/ID pipeline register; FETCH_PERF_CNT_EN builds the stall/flush counters
module if_id_fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        IF_Flush,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_valid,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  // PC: hold on stall, otherwise redirect to the word-aligned target or advance
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= PC_RESET & ~32'd3;
    else if (PCWrite) pc <= PCSrc ? (branch_target & ~32'd3) : pc_plus4;
  // IF/ID: flush beats hold, so a taken branch always leaves a bubble
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_PC4   <= '0;
      IF_ID_valid <= 1'b0;
    end else if (IF_Flush) begin
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_PC4   <= '0;
      IF_ID_valid <= 1'b0;
    end else if (IF_ID_Write) begin
      IF_ID_Instr <= imem_data;
      IF_ID_PC4   <= pc_plus4;
      IF_ID_valid <= 1'b1;
    end
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;
  // saturating event counters, cleared only by reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!PCWrite && !IF_ID_Write && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (IF_Flush && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
    end
  assign stall_count = stall_q;
  assign flush_count = flush_q;
`else
  assign stall_count = 16'h0000;
  assign flush_count = 16'h0000;
`endif
endmodule

// File: doc/if_id_fetch_stage.md
# if_id_fetch_stage

- Fetch-stage front end of the 5-stage MIPS pipeline: holds the PC, drives the instruction-memory address, and owns the IF/ID pipeline register.
- It is the consumer of the hazard unit's control outputs:
  - PCWrite and IF_ID_Write freeze the stage on load-use stalls.
  - IF_Flush squashes the fetched instruction on a taken branch.
  - PCSrc redirects the PC to the branch target.
- Sits between instruction memory and the ID stage.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word written into IF/ID on flush and reset (sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- PCWrite  in  1  1 = PC may update this cycle; 0 = PC holds.
- IF_ID_Write  in  1  1 = IF/ID may load this cycle; 0 = IF/ID holds.
- IF_Flush  in  1  1 = replace IF/ID contents with NOP.
- PCSrc  in  1  1 = next PC is branch_target.
- branch_target  in  32  branch/jump target computed in ID.
- imem_addr  out  32  current PC, combinational from the PC register.
- imem_data  in  32  instruction word, combinational read of imem_addr.
- IF_ID_PC4  out  32  registered PC+4 of the instruction in ID.
- IF_ID_Instr  out  32  registered instruction in ID.
- IF_ID_valid  out  1  1 = IF/ID holds a real fetched instruction.
- stall_count  out  16  stall-cycle counter (see Configuration).
- flush_count  out  16  flush-event counter (see Configuration).

## Operation
- **PC register:** pc[31:0]. pc[1:0] is always 0, and branch_target[1:0] is ignored.
- **pc_plus4** = pc + 4, computed modulo 2^32. At pc = 32'hFFFF_FFFC it wraps to 32'h0000_0000.
- **Next PC** (evaluated at each rising edge, in priority order):
  1. PCWrite=0: hold.
  2. PCSrc=1: {branch_target[31:2],2'b00}.
  3. Otherwise: pc_plus4.
- **PCSrc=1 with PCWrite=0:** the PC holds and the redirect is lost. The hazard unit never drives this combination; the bench flags it with an assertion only.
- **IF/ID register** (evaluated at each rising edge, in priority order):
  1. IF_Flush=1: IF_ID_Instr=NOP_INSTR, IF_ID_PC4=0, IF_ID_valid=0. Flush overrides IF_ID_Write=0.
  2. IF_ID_Write=1: IF_ID_Instr=imem_data, IF_ID_PC4=pc_plus4, IF_ID_valid=1.
  3. Otherwise: hold all three.
- **Simultaneous PCSrc=1 and IF_Flush=1** (normal taken-branch case):
  - PC loads the target.
  - IF/ID loads the bubble.
  - The instruction at the old PC is discarded.
- **Reset** (asynchronous, any time, including mid-stall or mid-flush): pc=PC_RESET, IF_ID_Instr=NOP_INSTR, IF_ID_PC4=0, IF_ID_valid=0, counters=0.
- **First real instruction** reaches IF/ID on the first rising edge after reset deasserts, provided IF_ID_Write=1.

## Timing
- imem_addr follows pc with zero latency.
- One-cycle latency from imem_data to IF_ID_Instr.
- Stall: every cycle with PCWrite=0 and IF_ID_Write=0 freezes both pc and IF/ID. Stall duration is unlimited.
- Branch penalty: exactly one bubble per taken branch. The target instruction appears in IF/ID two edges after the cycle PCSrc is sampled.
- Reset values: imem_addr=PC_RESET, IF_ID_PC4=0, IF_ID_Instr=NOP_INSTR, IF_ID_valid=0, stall_count=0, flush_count=0.
- All registers update only on rising clk, except the asynchronous reset.

## Configuration
- Macro: `FETCH_PERF_CNT_EN`.
- **Defined:**
  - stall_count increments on every edge where PCWrite=0 and IF_ID_Write=0.
  - flush_count increments on every edge where IF_Flush=1.
  - Both counters saturate at 16'hFFFF and clear only on reset.
- **Undefined:**
  - Counter logic is not built.
  - stall_count and flush_count remain as ports and are tied to 16'h0000, so the port list is identical in both builds.

## Test plan
- **Reset and sequential fetch:** reset 3 cycles, release with PCWrite=IF_ID_Write=1.
  - imem_addr = 0, 4, 8, ...
  - After the 1st edge: IF_ID_PC4=4, IF_ID_Instr=word@0, IF_ID_valid=1.
- **Load-use stall:** at pc=32'h10, drive PCWrite=IF_ID_Write=0 for 2 cycles.
  - pc stays 32'h10 and IF/ID is unchanged.
  - With the macro defined, stall_count=2.
  - Release: pc becomes 32'h14 on the next edge.
- **Taken branch:** at pc=32'h20, pulse PCSrc=IF_Flush=1 with branch_target=32'h0000_0103.
  - Next edge: pc=32'h100, IF_ID_Instr=NOP_INSTR, IF_ID_valid=0.
  - Following edge: IF_ID_PC4=32'h104.
- **Flush over hold:** drive IF_Flush=1 with IF_ID_Write=0 → IF/ID is bubbled anyway and IF_ID_valid=0.
- **Wrap-around:** run from PC_RESET=32'hFFFF_FFF8 → imem_addr goes FFFF_FFF8, FFFF_FFFC, 0000_0000, and IF_ID_PC4 = FFFF_FFFC, then 0.
- **Async reset mid-stall:** assert reset between edges during a stall.
  - Outputs return immediately to their reset values.
  - Counters read 0 (macro defined) or 0 (macro undefined).
